// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg: shared PHY types and frame-size helper
package pcie_phy_pkg;
    typedef enum logic [1:0] {IDLE, SEND, PAUSE} tx_ser_state_e;
    function automatic int bytes_per_frame(input int width);
        return width / 8;
    endfunction
endpackage

// File: rtl/phy_sync_fifo.sv
// phy_sync_fifo: synchronous word FIFO with registered level and head-of-queue read
module phy_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= do_push ? wptr + 1'b1 : wptr;
            rptr  <= do_pop ? rptr + 1'b1 : rptr;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer: buffers MAC frames and emits them LSB-byte-first with pause handshake
module tx_frame_serializer
    import pcie_phy_pkg::*;
#(
    parameter int MAC_FRAME_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [MAC_FRAME_WIDTH-1:0]     mac_data_frame_i,
    input  logic                           mac_data_frame_valid_i,
    output logic                           mac_data_frame_ready_o,
    input  logic                           os_pause_req_i,
    output logic                           os_pause_ack_o,
    output logic [7:0]                     data_byte_o,
    output logic                           data_byte_valid_o,
    input  logic                           data_byte_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);
    localparam int BYTES = bytes_per_frame(MAC_FRAME_WIDTH);
    localparam int IW    = BYTES > 1 ? $clog2(BYTES) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    tx_ser_state_e state, state_nx;
    logic [IW-1:0] idx;
    logic [MAC_FRAME_WIDTH-1:0] head;
    logic init_done, full, empty, push, xfer, last;
    assign mac_data_frame_ready_o = !full && init_done;
    assign push              = mac_data_frame_valid_i && mac_data_frame_ready_o;
    assign data_byte_valid_o = state == SEND;
    assign os_pause_ack_o    = state == PAUSE;
    assign xfer              = data_byte_valid_o && data_byte_ready_i;
    assign last              = xfer && idx == IW'(BYTES - 1);
    assign data_byte_o       = data_byte_valid_o ? head[8*idx +: 8] : 8'h00;
    phy_sync_fifo #(.WIDTH(MAC_FRAME_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (last),
        .wdata (mac_data_frame_i),
        .head  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level_o)
    );
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            idx       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= last ? '0 : xfer ? idx + 1'b1 : idx;
            init_done <= 1'b1;
        end
    end
    // A pause request only takes effect once the word in flight has fully drained
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = os_pause_req_i ? PAUSE : !empty ? SEND : IDLE;
            SEND:    state_nx = !last ? SEND : os_pause_req_i ? PAUSE :
                                (fifo_level_o == LW'(1) && !push) ? IDLE : SEND;
            PAUSE:   state_nx = os_pause_req_i ? PAUSE : !empty ? SEND : IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb_tx_frame_serializer: directed scenarios plus random traffic against a byte-stream model
module tb_tx_frame_serializer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] mac_data_frame_i = '0;
    logic        mac_data_frame_valid_i = 1'b0;
    logic        mac_data_frame_ready_o;
    logic        os_pause_req_i = 1'b0;
    logic        os_pause_ack_o;
    logic [7:0]  data_byte_o;
    logic        data_byte_valid_o;
    logic        data_byte_ready_i = 1'b0;
    logic [2:0]  fifo_level_o;
    int checks = 0;
    int errors = 0;

    tx_frame_serializer #(.MAC_FRAME_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .mac_data_frame_i       (mac_data_frame_i),
        .mac_data_frame_valid_i (mac_data_frame_valid_i),
        .mac_data_frame_ready_o (mac_data_frame_ready_o),
        .os_pause_req_i         (os_pause_req_i),
        .os_pause_ack_o         (os_pause_ack_o),
        .data_byte_o            (data_byte_o),
        .data_byte_valid_o      (data_byte_valid_o),
        .data_byte_ready_i      (data_byte_ready_i),
        .fifo_level_o           (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check({tag, "_valid"}, 32'(data_byte_valid_o), 32'd1);
            check({tag, "_byte"}, 32'(data_byte_o), 32'(w[8*i +: 8]));
        end
    endtask

    task automatic push_frame(input logic [31:0] w);
        @(negedge clk_i);
        mac_data_frame_i = w;
        mac_data_frame_valid_i = 1'b1;
        @(negedge clk_i);
        mac_data_frame_valid_i = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int lvl, sent, b;
        logic prev_req;
        logic [31:0] w;
        logic do_push, do_byte;
        // reset held low
        repeat (5) @(negedge clk_i);
        check("rst_ready", 32'(mac_data_frame_ready_o), 32'd0);
        check("rst_ack", 32'(os_pause_ack_o), 32'd0);
        check("rst_byte", 32'(data_byte_o), 32'd0);
        check("rst_valid", 32'(data_byte_valid_o), 32'd0);
        check("rst_level", 32'(fifo_level_o), 32'd0);
        rst_i = 1'b1;
        #1 check("rel_ready_early", 32'(mac_data_frame_ready_o), 32'd0);
        @(negedge clk_i);
        check("rel_ready", 32'(mac_data_frame_ready_o), 32'd1);
        check("rel_level", 32'(fifo_level_o), 32'd0);
        // single frame
        data_byte_ready_i = 1'b1;
        push_frame(32'hDDCC_BBAA);
        check("single_lat_valid", 32'(data_byte_valid_o), 32'd0);
        check("single_lat_level", 32'(fifo_level_o), 32'd1);
        expect_word("single", 32'hDDCC_BBAA);
        @(negedge clk_i);
        check("single_end_valid", 32'(data_byte_valid_o), 32'd0);
        check("single_end_level", 32'(fifo_level_o), 32'd0);
        // backpressure and full
        data_byte_ready_i = 1'b0;
        mac_data_frame_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            mac_data_frame_i = w;
            @(negedge clk_i);
        end
        repeat (2) @(negedge clk_i);
        check("full_ready", 32'(mac_data_frame_ready_o), 32'd0);
        check("full_level", 32'(fifo_level_o), 32'd4);
        mac_data_frame_valid_i = 1'b0;
        b = 0;
        for (int c = 0; c < 60 && b < 16; c++) begin
            check("bp_valid", 32'(data_byte_valid_o), 32'd1);
            check("bp_byte", 32'(data_byte_o), 32'(b));
            data_byte_ready_i = c[0];
            if (data_byte_ready_i) b++;
            @(negedge clk_i);
        end
        check("bp_count", 32'(b), 32'd16);
        check("bp_end_valid", 32'(data_byte_valid_o), 32'd0);
        check("bp_end_level", 32'(fifo_level_o), 32'd0);
        // pause mid-word
        data_byte_ready_i = 1'b1;
        push_frame(32'h4433_2211);
        @(negedge clk_i);
        check("pm_b0", 32'(data_byte_o), 32'h11);
        @(negedge clk_i);
        check("pm_b1", 32'(data_byte_o), 32'h22);
        os_pause_req_i = 1'b1;
        @(negedge clk_i);
        check("pm_b2", 32'(data_byte_o), 32'h33);
        check("pm_b2_ack", 32'(os_pause_ack_o), 32'd0);
        @(negedge clk_i);
        check("pm_b3", 32'(data_byte_o), 32'h44);
        check("pm_b3_valid", 32'(data_byte_valid_o), 32'd1);
        @(negedge clk_i);
        check("pm_ack", 32'(os_pause_ack_o), 32'd1);
        check("pm_valid", 32'(data_byte_valid_o), 32'd0);
        mac_data_frame_i = 32'h8877_6655;
        mac_data_frame_valid_i = 1'b1;
        @(negedge clk_i);
        mac_data_frame_valid_i = 1'b0;
        check("pm_level", 32'(fifo_level_o), 32'd1);
        check("pm_ack_hold", 32'(os_pause_ack_o), 32'd1);
        os_pause_req_i = 1'b0;
        expect_word("resume", 32'h8877_6655);
        check("resume_ack", 32'(os_pause_ack_o), 32'd0);
        // pause from idle
        @(negedge clk_i);
        check("pi_valid", 32'(data_byte_valid_o), 32'd0);
        os_pause_req_i = 1'b1;
        @(negedge clk_i);
        check("pi_ack", 32'(os_pause_ack_o), 32'd1);
        os_pause_req_i = 1'b0;
        @(negedge clk_i);
        check("pi_ack_off", 32'(os_pause_ack_o), 32'd0);
        check("pi_valid_off", 32'(data_byte_valid_o), 32'd0);
        // reset mid-operation
        mac_data_frame_valid_i = 1'b1;
        mac_data_frame_i = 32'hDDCC_BBAA;
        @(negedge clk_i);
        mac_data_frame_i = 32'h1111_1111;
        @(negedge clk_i);
        mac_data_frame_i = 32'h2222_2222;
        @(negedge clk_i);
        mac_data_frame_valid_i = 1'b0;
        check("rm_bb", 32'(data_byte_o), 32'hBB);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rm_level", 32'(fifo_level_o), 32'd0);
        check("rm_valid", 32'(data_byte_valid_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        push_frame(32'h0102_0304);
        expect_word("rm_new", 32'h0102_0304);
        @(negedge clk_i);
        check("rm_new_end", 32'(data_byte_valid_o), 32'd0);
        check("rm_new_level", 32'(fifo_level_o), 32'd0);
        // random traffic against a byte-stream model
        lvl = 0;
        sent = 0;
        prev_req = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check("rnd_level", 32'(fifo_level_o), 32'(lvl));
            check("rnd_ready", 32'(mac_data_frame_ready_o), 32'(lvl < 4));
            if (data_byte_valid_o) begin
                check("rnd_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("rnd_byte", 32'(data_byte_o), 32'(exp_q[0]));
            end else begin
                check("rnd_idle_byte", 32'(data_byte_o), 32'd0);
            end
            if (os_pause_ack_o) begin
                check("rnd_ack_valid", 32'(data_byte_valid_o), 32'd0);
                check("rnd_ack_boundary", 32'(sent % 4), 32'd0);
            end
            if (!prev_req) check("rnd_ack_noreq", 32'(os_pause_ack_o), 32'd0);
            if (c < 2900) begin
                mac_data_frame_valid_i = 1'($urandom_range(0, 1));
                mac_data_frame_i = $urandom;
                data_byte_ready_i = $urandom_range(0, 3) != 0;
                if ($urandom_range(0, 15) == 0) os_pause_req_i = ~os_pause_req_i;
            end else begin
                mac_data_frame_valid_i = 1'b0;
                data_byte_ready_i = 1'b1;
                os_pause_req_i = 1'b0;
            end
            do_push = mac_data_frame_valid_i && mac_data_frame_ready_o;
            do_byte = data_byte_valid_o && data_byte_ready_i;
            if (do_byte && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                sent++;
                if (sent % 4 == 0) lvl--;
            end
            if (do_push) begin
                for (int i = 0; i < 4; i++) exp_q.push_back(mac_data_frame_i[8*i +: 8]);
                lvl++;
            end
            prev_req = os_pause_req_i;
            @(negedge clk_i);
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_final_level", 32'(fifo_level_o), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Upstream TX stage of the physical layer. Accepts MAC_FRAME_WIDTH-bit frames from the Data Link Layer over a valid/ready handshake and buffers them in a small FIFO. Emits them LSB-byte-first as an 8-bit symbol stream to the multi-lane controller. Supports a pause handshake so the controller can inject ordered sets at a frame boundary.

## Interface
- MAC_FRAME_WIDTH, 32, input frame width; must be a multiple of 8; BYTES = MAC_FRAME_WIDTH/8
- FIFO_DEPTH, 4, frame buffer depth in words; power of two, ≥2
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset; asynchronous assert, active-low (0 = reset)
- mac_data_frame_i  in  MAC_FRAME_WIDTH  frame from DLL
- mac_data_frame_valid_i  in  1  frame valid
- mac_data_frame_ready_o  out  1  FIFO can accept
- os_pause_req_i  in  1  controller requests stream pause for ordered-set insertion
- os_pause_ack_o  out  1  stream paused at a word boundary
- data_byte_o  out  8  current byte
- data_byte_valid_o  out  1  byte valid
- data_byte_ready_i  in  1  downstream accepts byte
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  words stored

## Operation
- Write: on valid && ready the frame is pushed; level +1.
- mac_data_frame_ready_o = !full && init_done. init_done is a flop that clears on reset and sets on the first clock after release.
- Full blocks writes even if a pop occurs in the same cycle; there is no fall-through.
- Byte index idx counts 0..BYTES-1. data_byte_o = head[8*idx +: 8] when valid, else 8'h00.
- A byte transfers on valid && ready, and idx increments. When the transfer happens at idx==BYTES-1, the head is popped and idx returns to 0.
- Simultaneous push and pop leaves the level unchanged.
- States:
  - IDLE: valid=0, ack=0.
    - req=1 → PAUSE.
    - Else level>0 → SEND.
  - SEND: valid=1.
    - After the last-byte transfer: req=1 → PAUSE.
    - Else, if the level after the pop (including a same-cycle push) is 0 → IDLE.
    - Else stay in SEND.
    - req is ignored mid-word; the word always completes.
  - PAUSE: valid=0, ack=1.
    - req=0 → SEND if level>0, else IDLE.
    - Writes are still accepted while paused.
- os_pause_ack_o is high only in PAUSE.
- req withdrawn before ack: no effect.
- valid/data stability: once valid is high, data_byte_o and valid hold until ready=1.
- Reset (including mid-operation): FIFO emptied, level 0, idx 0, state IDLE. Any partially sent word is discarded.

## Timing
- Reset values: mac_data_frame_ready_o=0, os_pause_ack_o=0, data_byte_o=8'h00, data_byte_valid_o=0, fifo_level_o=0.
- ready_o rises one clock after rst_i deasserts.
- Latency: a frame accepted at edge N into an empty, idle block gives first byte valid after edge N+1.
- Throughput: 1 byte/clock with ready held high. Back-to-back words do not return to IDLE and have no bubble.
- Pause: req at cycle C during SEND gives ack after the edge that completes the current word's last byte. From IDLE, ack follows the next edge.
- Resume: req deasserted at cycle C gives valid after the next edge, if level>0.
- fifo_level_o is registered and reflects pushes/pops from the previous edge.

## Structure
- Shared package pcie_phy_pkg:
  - tx_ser_state_e {IDLE, SEND, PAUSE}
  - localparam BYTES_PER_FRAME derivation helper
- Sub-module phy_sync_fifo (parameterised width/depth):
  - ports: push, pop, wdata, rdata head, full, empty, level
  - async active-low reset
- Serializer FSM, idx counter and byte mux live in tx_frame_serializer.

## Test plan
- Reset release: hold rst_i=0 5 cycles → all outputs 0. Release → ready_o=1 one clock later; level=0.
- Single frame: push 32'hDDCC_BBAA, ready_i=1 → bytes AA, BB, CC, DD on 4 consecutive cycles, first valid after edge N+1. Then valid=0 and state IDLE.
- Backpressure and full: push 5 frames with ready_i=0 → 4 accepted, ready_o=0 with level=4 and 5th stalls. Toggle ready_i 1/0 → data held stable while ready_i=0, all 16 bytes in order, no gap between words when ready_i=1.
- Pause mid-word: during byte idx=1 of 32'h44332211 assert req → 33, 44 still sent, then ack=1 and valid=0. Push 32'h88776655 during pause → level=1. Drop req → 55 appears after next edge.
- Pause from IDLE: req with empty FIFO → ack next cycle. Withdraw → IDLE.
- Reset mid-operation: assert rst_i after byte BB of 32'hDDCC_BBAA with 2 words queued → level 0, valid 0 immediately (async). After release, a new push 32'h01020304 emits 04, 03, 02, 01 only.
